// File: rtl/i2c_master_seq.sv
// i2c_master_seq: byte-level I2C master sequencer (START, addr+R/W, N data bytes, STOP)
// Ports:
//   pclk, presetn          clock, asynchronous active-low reset
//   config_reg             [7:1] slave address, [0] R/W (1 = read)
//   control_reg            [0] en, [1] go (rising edge starts), [7:4] byte count N
//   tx_data/tx_empty/tx_rd TX FIFO head, empty flag, one-cycle pop
//   rx_full/rx_data/rx_wr  RX FIFO full flag, pushed byte, one-cycle push
//   sda_in                 synchronised SDA level
//   sda_oe/scl_oe          1 = pull line low
//   busy/done/nack         status: in progress, STOP-complete pulse, sticky slave NACK
module i2c_master_seq #(
   parameter int DATA_SIZE = 8,
   parameter int QDIV      = 250
) (
   input  logic                 pclk,
   input  logic                 presetn,
   input  logic [DATA_SIZE-1:0] config_reg,
   input  logic [DATA_SIZE-1:0] control_reg,
   input  logic [DATA_SIZE-1:0] tx_data,
   input  logic                 tx_empty,
   output logic                 tx_rd,
   input  logic                 rx_full,
   output logic [DATA_SIZE-1:0] rx_data,
   output logic                 rx_wr,
   input  logic                 sda_in,
   output logic                 sda_oe,
   output logic                 scl_oe,
   output logic                 busy,
   output logic                 done,
   output logic                 nack
);
   localparam int QW = $clog2(QDIV);
   typedef enum logic [3:0] {IDLE, START, ADDR, AACK, WLOAD, WR, WACK, RD, RPUSH, MACK, STOP} state_t;
   state_t state, state_nx;
   logic [QW-1:0] qcnt;
   logic [1:0] phase;
   logic [2:0] bit_cnt;
   logic [3:0] byte_cnt, n;
   logic [DATA_SIZE-1:0] shreg;
   logic rw, samp, go_d, en, timed, qend, bit_end, samp_pt, accept, unused;
   assign unused = &control_reg[3:2];
   assign en = control_reg[0];
   // stall states and IDLE freeze the quarter counter
   assign timed = !(state == IDLE || state == WLOAD || state == RPUSH);
   assign qend = qcnt == QW'(QDIV - 1);
   assign bit_end = timed && qend && phase == 2'd3;
   assign samp_pt = timed && qend && phase == 2'd2;
   assign accept = state == IDLE && en && control_reg[1] && !go_d;
   assign busy = state != IDLE;
   assign rx_data = rx_wr ? shreg : '0;
   assign scl_oe = state == WLOAD || state == RPUSH ||
                   (state == START ? phase == 2'd3 : state == STOP ? phase == 2'd0 : timed && !phase[1]);
   assign sda_oe = state == START ? phase[1] : state == STOP ? !phase[1] :
                   (state == ADDR || state == WR) ? !shreg[DATA_SIZE-1] : state == MACK && byte_cnt != n;
   always_comb begin
      state_nx = state;
      tx_rd = 1'b0;
      rx_wr = 1'b0;
      unique case (state)
         IDLE:  if (accept) state_nx = START;
         START: if (bit_end) state_nx = ADDR;
         ADDR, WR, RD: if (bit_end && bit_cnt == 3'd7) state_nx = state == ADDR ? AACK : state == WR ? WACK : RPUSH;
         AACK:  if (bit_end) state_nx = (samp || n == 4'd0) ? STOP : rw ? RD : WLOAD;
         WLOAD: if (!en) state_nx = STOP;
                else if (!tx_empty) begin
                   tx_rd = 1'b1;
                   state_nx = WR;
                end
         WACK:  if (bit_end) state_nx = (samp || byte_cnt + 4'd1 == n) ? STOP : WLOAD;
         RPUSH: if (!en) state_nx = STOP;
                else if (!rx_full) begin
                   rx_wr = 1'b1;
                   state_nx = MACK;
                end
         MACK:  if (bit_end) state_nx = byte_cnt == n ? STOP : RD;
         STOP:  if (bit_end) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // en dropped: let the current bit finish, then close the bus
      if (bit_end && !en && state != STOP) state_nx = STOP;
   end
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
         qcnt <= '0;
         phase <= '0;
         bit_cnt <= '0;
         byte_cnt <= '0;
         n <= '0;
         rw <= 1'b0;
         shreg <= '0;
         samp <= 1'b0;
         go_d <= 1'b0;
         nack <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_nx;
         go_d <= control_reg[1];
         done <= state == STOP && bit_end;
         if (timed) begin
            qcnt <= qend ? '0 : qcnt + 1'b1;
            if (qend) phase <= phase + 2'd1;
         end
         if (samp_pt) samp <= sda_in;
         if (samp_pt && state == RD) shreg <= {shreg[DATA_SIZE-2:0], sda_in};
         if (bit_end && (state == ADDR || state == WR)) shreg <= {shreg[DATA_SIZE-2:0], 1'b0};
         if (bit_end && (state == ADDR || state == WR || state == RD)) bit_cnt <= bit_cnt + 3'd1;
         if (bit_end && (state == AACK || state == WACK) && samp) nack <= 1'b1;
         if ((bit_end && state == WACK) || rx_wr) byte_cnt <= byte_cnt + 4'd1;
         if (tx_rd) shreg <= tx_data;
         if (accept) begin
            shreg <= config_reg;
            rw <= config_reg[0];
            n <= control_reg[7:4];
            nack <= 1'b0;
            byte_cnt <= '0;
            bit_cnt <= '0;
            qcnt <= '0;
            phase <= '0;
         end
      end
   end
endmodule
